// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the bus transfer scheduler: FSM encoding and
// elaboration-time helpers for select-width checks.
package bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        LATCH   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    function automatic logic sel_in_range(input int idx, input int nreg);
        return (idx < nreg);
    endfunction

endpackage

// File: rtl/bus_xfer_sched_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last
// winner and wraps, so every requester is served within NREQ grants.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            any_req
);

    logic            found_s;
    logic [IDXW-1:0] cand_s;

    // First requester at or after last_grant+1, modulo NREQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = IDXW'((int'(last_grant) + k) % NREQ);
            if (!found_s && req[cand_s]) begin
                found_s   = 1'b1;
                grant_idx = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            grant[grant_idx] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/bus_xfer_sched.sv
// Register-to-register transfer sequencer for a shared tri-state bus:
// one source read enable, one destination write enable, dead cycle between.
module bus_xfer_sched
    import bus_ctrl_pkg::*;
#(
    parameter int NREG = 4,
    parameter int NREQ = 2,
    parameter int SELW = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SELW-1:0] src_sel,
    input  logic [NREQ*SELW-1:0] dst_sel,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [NREG-1:0]      rd_en_n,
    output logic [NREG-1:0]      wr_en_n,
    output logic                 busy
);

    localparam int IDXW = (NREQ > 1) ? clog2(NREQ) : 1;

    if (SELW < clog2(NREG)) begin : g_selw_check
        $error("bus_xfer_sched: SELW too narrow for NREG");
    end

    state_t          state_r;
    logic [SELW-1:0] src_r;
    logic [SELW-1:0] dst_r;
    logic [IDXW-1:0] win_r;
    logic [IDXW-1:0] last_grant_r;

    logic [NREQ-1:0] arb_grant_s;
    logic [IDXW-1:0] arb_idx_s;
    logic            arb_any_s;
    logic [SELW-1:0] sel_src_s;
    logic [SELW-1:0] sel_dst_s;
    logic            legal_s;

    function automatic logic [NREG-1:0] reg_onehot(input logic [SELW-1:0] idx);
        logic [NREG-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << idx;
    endfunction

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant_r),
        .grant      (arb_grant_s),
        .grant_idx  (arb_idx_s),
        .any_req    (arb_any_s)
    );

    assign sel_src_s = src_sel[int'(arb_idx_s)*SELW +: SELW];
    assign sel_dst_s = dst_sel[int'(arb_idx_s)*SELW +: SELW];
    assign legal_s   = (sel_src_s != sel_dst_s)
                     && sel_in_range(int'(sel_src_s), NREG)
                     && sel_in_range(int'(sel_dst_s), NREG);

    // Transfer FSM; every output is a register so nothing combinational reaches the pins.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r      <= IDLE;
            src_r        <= '0;
            dst_r        <= '0;
            win_r        <= '0;
            last_grant_r <= '0;
            gnt          <= '0;
            done         <= '0;
            err          <= 1'b0;
            rd_en_n      <= '1;
            wr_en_n      <= '1;
            busy         <= 1'b0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (arb_any_s) begin
                        src_r <= sel_src_s;
                        dst_r <= sel_dst_s;
                        win_r <= arb_idx_s;
                        gnt   <= arb_grant_s;
                        busy  <= 1'b1;
                        if (legal_s) begin
                            state_r <= DRIVE;
                            rd_en_n <= ~reg_onehot(sel_src_s);
                        end else begin
                            // Rejected: skip straight to turnaround, bus never touched.
                            state_r <= RELEASE;
                            done    <= arb_grant_s;
                            err     <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DRIVE: begin
                    state_r <= LATCH;
                    wr_en_n <= ~reg_onehot(dst_r);
                end
                LATCH: begin
                    state_r <= RELEASE;
                    rd_en_n <= '1;
                    wr_en_n <= '1;
                    done    <= gnt;
                end
                RELEASE: begin
                    state_r      <= IDLE;
                    gnt          <= '0;
                    busy         <= 1'b0;
                    last_grant_r <= win_r;
                end
                default: begin
                    state_r <= IDLE;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    rd_en_n <= '1;
                    wr_en_n <= '1;
                end
            endcase
        end
    end

endmodule
